alarm_set_ctrl: RTL

//  Sequences alarm-time setting. Walks the operator through four digit fields:

---
 rtl/alarm_ctrl_pkg.sv | 50 +++++
 rtl/btn_edge_repeat.sv | 78 +++++++
 rtl/alarm_set_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_pkg.sv
// alarm_ctrl_pkg: shared definitions for the alarm-time setting controller.
//   - state encoding (IDLE=0 .. SET_M1=4)
//   - one-hot field-enable constants, ordered {h10, h1, m10, m1}
//   - default tick rates for timeout and auto-repeat
package alarm_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned FIELD_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    SET_H10 = 3'd1,
    SET_H1  = 3'd2,
    SET_M10 = 3'd3,
    SET_M1  = 3'd4
  } state_e;

  localparam logic [FIELD_W-1:0] FIELD_NONE = 4'b0000;
  localparam logic [FIELD_W-1:0] FIELD_H10  = 4'b1000;
  localparam logic [FIELD_W-1:0] FIELD_H1   = 4'b0100;
  localparam logic [FIELD_W-1:0] FIELD_M10  = 4'b0010;
  localparam logic [FIELD_W-1:0] FIELD_M1   = 4'b0001;

  localparam int unsigned DEF_TIMEOUT_TICKS = 40;
  localparam int unsigned DEF_REPEAT_DELAY  = 8;
  localparam int unsigned DEF_REPEAT_RATE   = 2;

  // One-hot field enable for a state; all zero outside the set states.
  function automatic logic [FIELD_W-1:0] field_of(input state_e s);
    case (s)
      SET_H10: field_of = FIELD_H10;
      SET_H1:  field_of = FIELD_H1;
      SET_M10: field_of = FIELD_M10;
      SET_M1:  field_of = FIELD_M1;
      default: field_of = FIELD_NONE;
    endcase
  endfunction

  // Field sequence advanced by each MODE press.
  function automatic state_e next_field(input state_e s);
    case (s)
      IDLE:    next_field = SET_H10;
      SET_H10: next_field = SET_H1;
      SET_H1:  next_field = SET_M10;
      SET_M10: next_field = SET_M1;
      default: next_field = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// btn_edge_repeat: rise detector for one UP/DOWN button, plus an optional
// hold-to-repeat counter clocked by the fast tick.
// Build option: ALARM_AUTOREPEAT_EN enables the repeat counter.
// Ports:
//   i_clk, i_reset_n  clock, synchronous active-low reset
//   i_btn             debounced button level
//   i_other_btn       level of the opposite-direction button
//   i_tick_fast       auto-repeat timebase enable
//   i_arm             controller is in a set state
//   i_clr             clear repeat counter (MODE rise or timeout)
//   o_rise_c          raw rise of i_btn (combinational)
//   o_step_c          step request: qualified rise or repeat (combinational)
module btn_edge_repeat #(
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  input  logic i_other_btn,
  input  logic i_tick_fast,
  input  logic i_arm,
  input  logic i_clr,
  output logic o_rise_c,
  output logic o_step_c
);

  logic r_btn_q;
  logic w_rise;

  assign w_rise   = i_btn & ~r_btn_q;
  assign o_rise_c = w_rise;

  // Previous-sample register for edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_btn_q <= 1'b0;
    else            r_btn_q <= i_btn;
  end

`ifdef ALARM_AUTOREPEAT_EN
  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_rep;
  logic             w_hold;
  logic             w_hit;

  // Repeat only runs while this button alone is held in a set state.
  assign w_hold = i_btn & ~i_other_btn & i_arm;
  assign w_hit  = w_hold & i_tick_fast &
                  (r_rep ? (r_cnt == CNT_W'(REPEAT_RATE - 1))
                         : (r_cnt == CNT_W'(REPEAT_DELAY - 1)));

  // First hit after the long delay, then switch to the short rate.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_rep <= 1'b0;
    end else if (!w_hold || i_clr) begin
      r_cnt <= '0;
      r_rep <= 1'b0;
    end else if (w_hit) begin
      r_cnt <= '0;
      r_rep <= 1'b1;
    end else if (i_tick_fast) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_step_c = (w_rise & ~i_other_btn) | w_hit;
`else
  logic w_unused;
  assign w_unused = ^{i_tick_fast, i_arm, i_clr};
  assign o_step_c = w_rise & ~i_other_btn;
`endif

endmodule

// File: rtl/alarm_set_ctrl.sv
// alarm_set_ctrl: alarm-time setting sequencer. MODE walks the four digit
// fields (H10, H1, M10, M1, back to idle); UP/DOWN become one-cycle step
// pulses with a direction flag for the selected counter. Set mode aborts
// after TIMEOUT_TICKS seconds without a button press.
// Build option: ALARM_AUTOREPEAT_EN enables hold-to-repeat on UP/DOWN.
// Ports:
//   i_clk, i_reset_n     clock, synchronous active-low reset
//   i_tick_1hz           1 Hz enable (timeout)
//   i_tick_fast          8 Hz enable (auto-repeat)
//   i_mode_btn           debounced MODE level
//   i_up_btn, i_down_btn debounced UP/DOWN levels
//   o_settime10..o_setmin1 field enables, one-hot in set states
//   o_bap_btn3           one-cycle step pulse
//   o_sel_down           step direction, 1 = down
//   o_set_active         high in any set state
module alarm_set_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE   = DEF_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick_1hz,
  input  logic i_tick_fast,
  input  logic i_mode_btn,
  input  logic i_up_btn,
  input  logic i_down_btn,
  output logic o_settime10,
  output logic o_settime1,
  output logic o_setmin10,
  output logic o_setmin1,
  output logic o_bap_btn3,
  output logic o_sel_down,
  output logic o_set_active
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS);

  state_e             r_state, w_state_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic               r_mode_q;
  logic [FIELD_W-1:0] r_field, w_field_nxt;
  logic               r_bap, w_bap_nxt;
  logic               r_sel, w_sel_nxt;
  logic               r_active, w_active_nxt;

  logic w_mode_rise, w_up_rise, w_dn_rise, w_up_step, w_dn_step;
  logic w_set, w_timeout;

  assign w_mode_rise = i_mode_btn & ~r_mode_q;
  assign w_set       = (r_state != IDLE);

  btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_btn       (i_up_btn),
    .i_other_btn (i_down_btn),
    .i_tick_fast (i_tick_fast),
    .i_arm       (w_set),
    .i_clr       (w_mode_rise | w_timeout),
    .o_rise_c    (w_up_rise),
    .o_step_c    (w_up_step)
  );

  btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_btn       (i_down_btn),
    .i_other_btn (i_up_btn),
    .i_tick_fast (i_tick_fast),
    .i_arm       (w_set),
    .i_clr       (w_mode_rise | w_timeout),
    .o_rise_c    (w_dn_rise),
    .o_step_c    (w_dn_step)
  );

  // State, timeout counter, MODE edge register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_tmo    <= '0;
      r_mode_q <= 1'b0;
      r_field  <= FIELD_NONE;
      r_bap    <= 1'b0;
      r_sel    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tmo    <= w_tmo_nxt;
      r_mode_q <= i_mode_btn;
      r_field  <= w_field_nxt;
      r_bap    <= w_bap_nxt;
      r_sel    <= w_sel_nxt;
      r_active <= w_active_nxt;
    end
  end

  // Next state, timeout and output values; MODE outranks every other event.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_timeout   = 1'b0;
    w_bap_nxt   = 1'b0;
    w_sel_nxt   = r_sel;

    if (w_mode_rise) begin
      w_state_nxt = next_field(r_state);
      w_tmo_nxt   = '0;
    end else if (w_set && (w_up_rise || w_dn_rise)) begin
      w_tmo_nxt = '0;
    end else if (w_set && i_tick_1hz) begin
      if (r_tmo == TMO_W'(TIMEOUT_TICKS - 1)) begin
        w_timeout   = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_tmo_nxt = r_tmo + TMO_W'(1);
      end
    end

    if (w_state_nxt == IDLE) w_tmo_nxt = '0;

    // Step sources are mutually exclusive: each requires the other button released.
    if (w_set && !w_mode_rise && !w_timeout) begin
      if (w_up_step) begin
        w_bap_nxt = 1'b1;
        w_sel_nxt = 1'b0;
      end else if (w_dn_step) begin
        w_bap_nxt = 1'b1;
        w_sel_nxt = 1'b1;
      end
    end

    w_field_nxt  = field_of(w_state_nxt);
    w_active_nxt = (w_state_nxt != IDLE);
  end

  assign o_settime10  = r_field[3];
  assign o_settime1   = r_field[2];
  assign o_setmin10   = r_field[1];
  assign o_setmin1    = r_field[0];
  assign o_bap_btn3   = r_bap;
  assign o_sel_down   = r_sel;
  assign o_set_active = r_active;

endmodule
